pong_graph_anim: RTL and testbench
==================================

// Module: pong_graph_anim
// PURPOSE
//  Pixel generator for the Pong display, downstream of vga_sync. Consumes the pixel
//  position and video_on from the sync unit and produces the 3-bit RGB for the VGA pins.
//  Draws a static left wall, a right paddle moved by two buttons, and a square ball.
//  Animation advances once per frame, at the refresh tick. Reports hit and miss events
//  for the score logic.
// PARAMETERS
//  MAX_X       640  visible width (pixels)
//  MAX_Y       480  visible height (pixels)
//  WALL_X_L    32   wall left column
//  WALL_X_R    35   wall right column (inclusive)
//  BAR_X_L     600  paddle left column
//  BAR_X_R     603  paddle right column (inclusive)
//  BAR_Y_SIZE  72   paddle height
//  BAR_V       4    paddle step per frame
//  BALL_SIZE   8    ball side length
//  BALL_V      2    ball speed per axis per frame
// PORTS
//  clk       in   1   system clock
//  reset     in   1   reset; asynchronous, active-high
//  p_tick    in   1   pixel enable from vga_sync
//  video_on  in   1   visible-area flag from vga_sync
//  pixel_x   in   10  current column
//  pixel_y   in   10  current row
//  btn       in   2   [0]=paddle down, [1]=paddle up; level, pre-debounced
//  hit       out  1   one-clk pulse on paddle contact
//  miss      out  1   one-clk pulse when the ball passes the paddle
//  rgb       out  3   pixel colour {R,G,B}
// BEHAVIOUR
//  - refr_tick = p_tick & (pixel_x==0) & (pixel_y==MAX_Y+1). One clk per frame.
//    All animation state changes only on refr_tick.
//  - Reset values: bar_y_t=(MAX_Y-BAR_Y_SIZE)/2=204; ball_x=(MAX_X-BALL_SIZE)/2=316;
//    ball_y=(MAX_Y-BALL_SIZE)/2=236; x_dir=+1; y_dir=+1; hit=0; miss=0; rgb=0.
//  - Edges: bar_y_b=bar_y_t+BAR_Y_SIZE-1; ball_x_r=ball_x+BALL_SIZE-1;
//    ball_y_b=ball_y+BALL_SIZE-1. Unsigned 10-bit arithmetic, no wrap permitted.
//  - Paddle moves down when btn==2'b01 and bar_y_b < MAX_Y-1-BAR_V: add BAR_V.
//  - Paddle moves up when btn==2'b10 and bar_y_t > BAR_V: subtract BAR_V.
//  - If btn==2'b00 or 2'b11, or the bound check fails, the paddle holds.
//  - Ball at refr_tick: the collision check uses the current position, then the
//    position moves by the new direction*BALL_V. Direction change and move take
//    effect in the same tick.
//  - Y axis: ball_y <= BALL_V sets y_dir=+1.
//    ball_y_b >= MAX_Y-1-BALL_V sets y_dir=-1.
//  - X axis priority:
//    miss: ball_x_r > BAR_X_R. Ball returns to its reset position with dirs reset.
//      miss=1 for that clk only.
//    paddle: BAR_X_L <= ball_x_r <= BAR_X_R and ball_y_b >= bar_y_t and
//      ball_y <= bar_y_b. Sets x_dir=-1; hit=1 for that clk only.
//    wall: ball_x <= WALL_X_R+BALL_V sets x_dir=+1.
//  - X and Y are evaluated independently; a corner hit flips both.
//  - Colour priority for the current pixel:
//    wall 3'b001 > paddle 3'b010 > ball 3'b100 > background 3'b110.
//  - When video_on==0, colour is 3'b000.
//  - rgb is registered every clk: one clk latency from pixel_x/pixel_y/video_on.
//  - Button changes between ticks have no effect until the next refr_tick.
//  - Reset mid-frame returns all state to reset values immediately; rgb=0 while asserted.
// TESTING
//  1. Assert reset, then release with btn=0.
//     -> rgb=0, hit=miss=0; first tick: ball 316->318 (x) and 236->238 (y); bar_y_t=204.
//  2. btn=2'b10 for 3 frames -> bar_y_t 204->192. btn=2'b11 for 1 frame -> holds at 192.
//  3. btn=2'b10 for 60 frames -> bar_y_t stops at 4 and never underflows.
//  4. Force ball_y=2 with y_dir=-1 -> next tick y_dir=+1, ball_y=4; no hit/miss pulse.
//  5. Ball at ball_x_r=600, ball_y=220, bar_y_t=204 -> hit pulses for exactly 1 clk;
//     ball_x decreases by 2.
//  6. Ball at ball_x_r=604, bar away -> miss pulses for 1 clk; ball at (316,236) with dirs +1.
//  7. Pixel (33,100) with video_on=1 -> rgb=001 one clk later. video_on=0 -> rgb=000.

Source files
------------

// File: rtl/pong_graph_anim.sv
// Pong pixel generator: left wall, button-driven right paddle and a square ball.
// Animation state advances once per frame on refr_tick; rgb is registered per clk.
module pong_graph_anim #(
   parameter int MAX_X      = 640,
   parameter int MAX_Y      = 480,
   parameter int WALL_X_L   = 32,
   parameter int WALL_X_R   = 35,
   parameter int BAR_X_L    = 600,
   parameter int BAR_X_R    = 603,
   parameter int BAR_Y_SIZE = 72,
   parameter int BAR_V      = 4,
   parameter int BALL_SIZE  = 8,
   parameter int BALL_V     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       p_tick,
   input  logic       video_on,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic [1:0] btn,
   output logic       hit,
   output logic       miss,
   output logic [2:0] rgb
);

   // 10-bit constants so every compare and add below is width-matched
   localparam logic [9:0] C_WALL_L   = 10'(WALL_X_L);
   localparam logic [9:0] C_WALL_R   = 10'(WALL_X_R);
   localparam logic [9:0] C_BAR_L    = 10'(BAR_X_L);
   localparam logic [9:0] C_BAR_R    = 10'(BAR_X_R);
   localparam logic [9:0] C_BAR_H1   = 10'(BAR_Y_SIZE - 1);
   localparam logic [9:0] C_BAR_V    = 10'(BAR_V);
   localparam logic [9:0] C_BAR_LIM  = 10'(MAX_Y - 1 - BAR_V);
   localparam logic [9:0] C_BALL_S1  = 10'(BALL_SIZE - 1);
   localparam logic [9:0] C_BALL_V   = 10'(BALL_V);
   localparam logic [9:0] C_BALL_YLIM = 10'(MAX_Y - 1 - BALL_V);
   localparam logic [9:0] C_WALL_BNC = 10'(WALL_X_R + BALL_V);
   localparam logic [9:0] C_REFR_Y   = 10'(MAX_Y + 1);
   localparam logic [9:0] BAR_Y0     = 10'((MAX_Y - BAR_Y_SIZE) / 2);
   localparam logic [9:0] BALL_X0    = 10'((MAX_X - BALL_SIZE) / 2);
   localparam logic [9:0] BALL_Y0    = 10'((MAX_Y - BALL_SIZE) / 2);

   logic       refr_tick;
   logic [9:0] bar_y_t, bar_y_b;
   logic [9:0] ball_x, ball_y, ball_x_r, ball_y_b;
   logic       x_dir, y_dir;            // 1 = increasing coordinate
   logic [9:0] ball_x_n, ball_y_n;
   logic       x_dir_n, y_dir_n, hit_n, miss_n;
   logic       wall_on, bar_on, ball_on;
   logic [2:0] rgb_n;

   assign refr_tick = p_tick && (pixel_x == 10'd0) && (pixel_y == C_REFR_Y);
   assign bar_y_b   = bar_y_t + C_BAR_H1;
   assign ball_x_r  = ball_x + C_BALL_S1;
   assign ball_y_b  = ball_y + C_BALL_S1;

   // paddle: one step per frame while a single button is held and there is room
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bar_y_t <= BAR_Y0;
      else if (refr_tick) begin
         if (btn == 2'b01 && bar_y_b < C_BAR_LIM)
            bar_y_t <= bar_y_t + C_BAR_V;
         else if (btn == 2'b10 && bar_y_t > C_BAR_V)
            bar_y_t <= bar_y_t - C_BAR_V;
      end
   end

   // ball: collisions judged on the current position, then move by the new direction
   always_comb begin
      x_dir_n  = x_dir;
      y_dir_n  = y_dir;
      ball_x_n = ball_x;
      ball_y_n = ball_y;
      hit_n    = 1'b0;
      miss_n   = 1'b0;
      if (ball_y <= C_BALL_V)
         y_dir_n = 1'b1;
      else if (ball_y_b >= C_BALL_YLIM)
         y_dir_n = 1'b0;
      if (ball_x_r > C_BAR_R) begin
         // passed the paddle: serve again from the centre
         miss_n   = 1'b1;
         x_dir_n  = 1'b1;
         y_dir_n  = 1'b1;
         ball_x_n = BALL_X0;
         ball_y_n = BALL_Y0;
      end else begin
         if (ball_x_r >= C_BAR_L && ball_y_b >= bar_y_t && ball_y <= bar_y_b) begin
            x_dir_n = 1'b0;
            hit_n   = 1'b1;
         end else if (ball_x <= C_WALL_BNC)
            x_dir_n = 1'b1;
         ball_x_n = x_dir_n ? ball_x + C_BALL_V : ball_x - C_BALL_V;
         ball_y_n = y_dir_n ? ball_y + C_BALL_V : ball_y - C_BALL_V;
      end
   end

   // ball state and single-clk event pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ball_x <= BALL_X0;
         ball_y <= BALL_Y0;
         x_dir  <= 1'b1;
         y_dir  <= 1'b1;
         hit    <= 1'b0;
         miss   <= 1'b0;
      end else begin
         hit  <= 1'b0;
         miss <= 1'b0;
         if (refr_tick) begin
            ball_x <= ball_x_n;
            ball_y <= ball_y_n;
            x_dir  <= x_dir_n;
            y_dir  <= y_dir_n;
            hit    <= hit_n;
            miss   <= miss_n;
         end
      end
   end

   // object masks and colour priority for the current pixel
   always_comb begin
      wall_on = (pixel_x >= C_WALL_L) && (pixel_x <= C_WALL_R);
      bar_on  = (pixel_x >= C_BAR_L) && (pixel_x <= C_BAR_R) &&
                (pixel_y >= bar_y_t) && (pixel_y <= bar_y_b);
      ball_on = (pixel_x >= ball_x) && (pixel_x <= ball_x_r) &&
                (pixel_y >= ball_y) && (pixel_y <= ball_y_b);
      rgb_n   = 3'b110;
      if (!video_on)
         rgb_n = 3'b000;
      else if (wall_on)
         rgb_n = 3'b001;
      else if (bar_on)
         rgb_n = 3'b010;
      else if (ball_on)
         rgb_n = 3'b100;
   end

   // registered colour output, one clk behind the pixel position
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rgb <= 3'b000;
      else
         rgb <= rgb_n;
   end

endmodule

// File: tb/tb_pong_graph_anim.sv
// Bench for pong_graph_anim: frame ticks with directed and random buttons, pixel
// probes around every object, compared against a plain integer game model.
module tb_pong_graph_anim;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       p_tick = 1'b0;
   logic       video_on = 1'b0;
   logic [9:0] pixel_x = '0;
   logic [9:0] pixel_y = '0;
   logic [1:0] btn = 2'b00;
   logic       hit, miss;
   logic [2:0] rgb;

   int cmp_cnt = 0;
   int err_cnt = 0;
   int dut_hits = 0, dut_miss = 0;
   int mdl_hits = 0, mdl_miss = 0;

   // game model: integer coordinates, directions as +1/-1
   int m_bar, m_bx, m_by, m_dx, m_dy;

   pong_graph_anim dut (
      .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .btn(btn),
      .hit(hit), .miss(miss), .rgb(rgb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_bar = 204; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
   endtask

   function automatic logic [2:0] mcol(input int x, input int y, input bit von);
      if (!von) return 3'b000;
      if (x >= 32 && x <= 35) return 3'b001;
      if (x >= 600 && x <= 603 && y >= m_bar && y <= m_bar + 71) return 3'b010;
      if (x >= m_bx && x <= m_bx + 7 && y >= m_by && y <= m_by + 7) return 3'b100;
      return 3'b110;
   endfunction

   // one frame of game rules, applied to the model; returns expected events
   task automatic model_step(input logic [1:0] b, output int eh, output int em);
      int ob, ndx, ndy;
      ob = m_bar; eh = 0; em = 0;
      if (b == 2'b01 && m_bar + 71 < 475) m_bar += 4;
      else if (b == 2'b10 && m_bar > 4) m_bar -= 4;
      ndy = m_dy;
      if (m_by <= 2) ndy = 1;
      else if (m_by + 7 >= 477) ndy = -1;
      if (m_bx + 7 > 603) begin
         em = 1;
         m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
      end else begin
         ndx = m_dx;
         if (m_bx + 7 >= 600 && m_by + 7 >= ob && m_by <= ob + 71) begin
            ndx = -1; eh = 1;
         end else if (m_bx <= 37) ndx = 1;
         m_dx = ndx; m_dy = ndy;
         m_bx += 2 * ndx; m_by += 2 * ndy;
      end
      mdl_hits += eh; mdl_miss += em;
   endtask

   // drive one refresh tick, then check the event pulses and their clearing
   task automatic do_tick(input logic [1:0] b);
      int eh, em;
      model_step(b, eh, em);
      btn = b; p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd481; video_on = 1'b0;
      @(negedge clk);
      check("hit", int'(hit), eh);
      check("miss", int'(miss), em);
      dut_hits += int'(hit); dut_miss += int'(miss);
      // pixel_x=1 on the refresh row is not a tick
      p_tick = 1'b1; pixel_x = 10'd1; btn = 2'($urandom);
      @(negedge clk);
      check("hit_clr", int'(hit), 0);
      check("miss_clr", int'(miss), 0);
   endtask

   task automatic probe(input int x, input int y, input bit von);
      pixel_x = 10'(x); pixel_y = 10'(y); video_on = von;
      p_tick = 1'($urandom); btn = 2'($urandom);
      @(negedge clk);
      check($sformatf("rgb(%0d,%0d)", x, y), int'(rgb), int'(mcol(x, y, von)));
   endtask

   // probe corners of the ball and paddle and the pixels just outside them
   task automatic probe_all();
      probe(m_bx, m_by, 1);
      probe(m_bx + 7, m_by + 7, 1);
      probe(m_bx - 1, m_by, 1);
      probe(m_bx + 8, m_by + 7, 1);
      probe(m_bx, m_by - 1, 1);
      probe(m_bx + 7, m_by + 8, 1);
      probe(600, m_bar, 1);
      probe(603, m_bar + 71, 1);
      probe(601, m_bar - 1, 1);
      probe(602, m_bar + 72, 1);
      probe($urandom_range(639, 0), $urandom_range(479, 0), 1);
   endtask

   initial begin
      logic [1:0] b;
      model_reset();
      // reset held: colour forced off even on a wall pixel
      pixel_x = 10'd33; pixel_y = 10'd100; video_on = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_rgb", int'(rgb), 0);
      check("rst_hit", int'(hit), 0);
      check("rst_miss", int'(miss), 0);
      reset = 1'b0;
      @(negedge clk);
      probe_all();

      // first frame with no buttons: ball to (318,238), paddle stays
      do_tick(2'b00);
      check("first_bx_model", m_bx, 318);
      probe_all();

      // paddle up three frames, both buttons one frame, then up to the top stop
      repeat (3) begin do_tick(2'b10); probe_all(); end
      do_tick(2'b11); probe_all();
      repeat (60) begin do_tick(2'b10); probe_all(); end

      // mostly tracking the ball, so paddle hits happen, with random overrides
      repeat (300) begin
         if ($urandom_range(4, 0) == 0) b = 2'($urandom);
         else if (m_by + 4 > m_bar + 40) b = 2'b01;
         else if (m_by + 4 < m_bar + 32) b = 2'b10;
         else b = 2'b00;
         do_tick(b); probe_all();
      end

      // fully random buttons
      repeat (250) begin do_tick(2'($urandom)); probe_all(); end

      // paddle parked at the bottom to provoke misses
      repeat (200) begin do_tick(2'b01); probe_all(); end

      // wall pixel visible, then blanked
      probe(33, 100, 1);
      probe(33, 100, 0);
      probe(36, 100, 1);

      // asynchronous reset in the middle of a clock phase
      pixel_x = 10'd33; pixel_y = 10'd100; video_on = 1'b1;
      #2 reset = 1'b1;
      #1 check("async_rst_rgb", int'(rgb), 0);
      @(negedge clk);
      check("rst_hold_rgb", int'(rgb), 0);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      probe_all();
      do_tick(2'b00);
      probe_all();

      check("hit_count", dut_hits, mdl_hits);
      check("miss_count", dut_miss, mdl_miss);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
